// File: rtl/booth_r4_multiplier.sv
// Radix-4 (modified Booth) sequential multiplier: two multiplier bits retired per cycle,
// signed or unsigned operands selected per operation, start/busy/done handshake.

// One Booth radix-4 iteration: recode {mq[1:0], q_m1}, add the selected
// multiple of mcand to acc, then arithmetic-shift {acc, mq, q_m1} right by two.
module booth_r4_step #(
    parameter int E = 34
) (
    input  logic [E+1:0] acc,
    input  logic [E-1:0] mq,
    input  logic         q_m1,
    input  logic [E+1:0] mcand,
    output logic [E+1:0] acc_next,
    output logic [E-1:0] mq_next,
    output logic         q_m1_next
);
    logic [E+1:0] mcand_x2;
    logic [E+1:0] addend;
    logic [E+1:0] sum;

    assign mcand_x2 = {mcand[E:0], 1'b0};

    always_comb begin
        addend = '0;
        unique case ({mq[1:0], q_m1})
            3'b001, 3'b010: addend = mcand;
            3'b011:         addend = mcand_x2;
            3'b100:         addend = -mcand_x2;
            3'b101, 3'b110: addend = -mcand;
            default:        addend = '0;
        endcase
    end

    assign sum       = acc + addend;
    assign acc_next  = {{2{sum[E+1]}}, sum[E+1:2]};
    assign mq_next   = {sum[1:0], mq[E-1:2]};
    assign q_m1_next = mq[1];
endmodule

module booth_r4_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    // Two guard bits on the operands let the unsigned case reuse signed Booth
    // recoding; two more on acc/mcand absorb the +/-2M partial sums.
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic signed [E+1:0] acc;
    logic [E-1:0]        mq;
    logic                q_m1;
    logic [E+1:0]        mcand;
    logic [CW-1:0]       cnt;

    logic [E+1:0]        acc_next;
    logic [E-1:0]        mq_next;
    logic                q_m1_next;
    logic                last_iter;

    booth_r4_step #(.E(E)) u_step (
        .acc       (acc),
        .mq        (mq),
        .q_m1      (q_m1),
        .mcand     (mcand),
        .acc_next  (acc_next),
        .mq_next   (mq_next),
        .q_m1_next (q_m1_next)
    );

    assign last_iter = (cnt == CW'(1));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            mq      <= '0;
            q_m1    <= 1'b0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mq    <= {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
                        q_m1  <= 1'b0;
                        mcand <= {{4{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
                        cnt   <= CW'(N);
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    mq   <= mq_next;
                    q_m1 <= q_m1_next;
                    cnt  <= cnt - 1'b1;
                    // Low 2*WIDTH bits of the final {acc, mq}; the dropped top bits are pure extension.
                    if (last_iter) product <= {acc_next[WIDTH-3:0], mq_next};
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Randomised bench for booth_r4_multiplier: 32-bit and 8-bit instances checked
// against exact integer products, plus handshake timing, reset abort and back-to-back.
module tb_booth_r4_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] m32 = '0, q32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  m8 = '0, q8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    booth_r4_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .multiplicand(m32), .multiplier(q32),
        .busy(busy32), .done(done32), .product(p32)
    );

    booth_r4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(m8), .multiplier(q8),
        .busy(busy8), .done(done8), .product(p8)
    );

    function automatic logic [63:0] ref32(input logic sm, input logic [31:0] m, input logic [31:0] q);
        longint a, b;
        if (sm) begin a = longint'($signed(m)); b = longint'($signed(q)); end
        else    begin a = longint'({32'b0, m}); b = longint'({32'b0, q}); end
        return 64'(a * b);
    endfunction

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] m, input logic [7:0] q);
        int a, b;
        if (sm) begin a = int'($signed(m)); b = int'($signed(q)); end
        else    begin a = int'({24'b0, m}); b = int'({24'b0, q}); end
        return 16'(a * b);
    endfunction

    function automatic logic [31:0] pick32();
        unique case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Launch one op and wait for done; lat counts cycles after the accepting edge.
    task automatic run32(input logic sm, input logic [31:0] m, input logic [31:0] q,
                         output logic [63:0] got, output int lat, output int busy_cnt);
        @(negedge clk); start32 = 1'b1; sm32 = sm; m32 = m; q32 = q;
        @(posedge clk);
        lat = -1; busy_cnt = 0; got = 'x;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin start32 = 1'b0; sm32 = ~sm; m32 = $urandom; q32 = $urandom; end
            if (busy32) busy_cnt++;
            if (done32) begin lat = i; got = p32; break; end
        end
    endtask

    task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] got, output int lat);
        @(negedge clk); start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
        @(posedge clk);
        lat = -1; got = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin start8 = 1'b0; sm8 = ~sm; m8 = 8'($urandom); q8 = 8'($urandom); end
            if (done8) begin lat = i; got = p8; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy32 !== 1'b0) begin failed++; $display("FAIL reset_busy32 got %b want 0", busy32); end
        tests++; if (done32 !== 1'b0) begin failed++; $display("FAIL reset_done32 got %b want 0", done32); end
        tests++; if (p32 !== 64'd0) begin failed++; $display("FAIL reset_p32 got %h want 0", p32); end
        tests++; if (p8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            failed++; $display("FAIL reset_dut8 got p=%h busy=%b done=%b want 0", p8, busy8, done8); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] got; int lat, bc;
        run32(1'b1, -32'sd10, 32'sd13, got, lat, bc);
        tests++; if (got !== 64'hFFFF_FFFF_FFFF_FF7E) begin failed++; $display("FAIL basic_product got %h want FFFFFFFFFFFFFF7E", got); end
        tests++; if (lat !== 17) begin failed++; $display("FAIL basic_latency got %0d want 17", lat); end
        tests++; if (bc !== 17) begin failed++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
    endtask

    task automatic test_boundary32();
        logic [63:0] got; int lat, bc;
        run32(1'b1, 32'h8000_0000, 32'h8000_0000, got, lat, bc);
        tests++; if (got !== 64'h4000_0000_0000_0000) begin failed++; $display("FAIL bnd_min_signed got %h want 4000000000000000", got); end
        run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, bc);
        tests++; if (got !== 64'hFFFF_FFFE_0000_0001) begin failed++; $display("FAIL bnd_max_unsigned got %h want FFFFFFFE00000001", got); end
        run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, lat, bc);
        tests++; if (got !== 64'd1) begin failed++; $display("FAIL bnd_neg1_signed got %h want 1", got); end
    endtask

    task automatic test_width8();
        logic [15:0] got; int lat;
        run8(1'b1, 8'h80, 8'h7F, got, lat);
        tests++; if (got !== 16'hC080) begin failed++; $display("FAIL w8_signed_min got %h want C080", got); end
        tests++; if (lat !== 5) begin failed++; $display("FAIL w8_latency got %0d want 5", lat); end
        run8(1'b0, 8'hFF, 8'hFF, got, lat);
        tests++; if (got !== 16'hFE01) begin failed++; $display("FAIL w8_unsigned_max got %h want FE01", got); end
        run8(1'b1, 8'h00, 8'hFF, got, lat);
        tests++; if (got !== 16'h0000) begin failed++; $display("FAIL w8_zero got %h want 0", got); end
        for (int k = 0; k < 300; k++) begin
            logic sm; logic [7:0] a, b;
            sm = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            run8(sm, a, b, got, lat);
            tests++; if (got !== ref8(sm, a, b)) begin failed++;
                $display("FAIL w8_sweep sm=%b %h*%h got %h want %h", sm, a, b, got, ref8(sm, a, b)); end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0, extra_busy = 0;
        logic [63:0] got = 'x;
        @(negedge clk); start32 = 1'b1; sm32 = 1'b0; m32 = 32'd6; q32 = 32'd7;
        @(posedge clk);
        @(negedge clk); start32 = 1'b0;
        repeat (5) @(negedge clk);
        start32 = 1'b1; m32 = 32'd100; q32 = 32'd100;
        @(negedge clk); start32 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dones > 0 && busy32) extra_busy++;
            if (done32) begin dones++; got = p32; end
        end
        tests++; if (dones !== 1) begin failed++; $display("FAIL ignore_done_count got %0d want 1", dones); end
        tests++; if (got !== 64'd42) begin failed++; $display("FAIL ignore_product got %0d want 42", got); end
        tests++; if (extra_busy !== 0) begin failed++; $display("FAIL ignore_second_op got %0d busy cycles want 0", extra_busy); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        logic [63:0] got; int lat, bc;
        @(negedge clk); start32 = 1'b1; sm32 = 1'b1; m32 = $urandom; q32 = $urandom;
        @(posedge clk);
        @(negedge clk); start32 = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (busy32 !== 1'b0) begin failed++; $display("FAIL rstmid_busy got %b want 0", busy32); end
        tests++; if (done32 !== 1'b0) begin failed++; $display("FAIL rstmid_done got %b want 0", done32); end
        tests++; if (p32 !== 64'd0) begin failed++; $display("FAIL rstmid_product got %h want 0", p32); end
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done32) dones++;
        end
        tests++; if (dones !== 0) begin failed++; $display("FAIL rstmid_late_done got %0d want 0", dones); end
        run32(1'b0, 32'd3, 32'd5, got, lat, bc);
        tests++; if (got !== 64'd15) begin failed++; $display("FAIL rstmid_restart got %0d want 15", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b; logic sm;
        logic [63:0] exp, last_p;
        int since = 0, ops = 0, bad_ov = 0, bad_st = 0;
        bit first = 1'b1;
        @(negedge clk);
        a = pick32(); b = pick32(); sm = 1'($urandom);
        start32 = 1'b1; sm32 = sm; m32 = a; q32 = b;
        exp = ref32(sm, a, b); last_p = p32;
        for (int cyc = 0; cyc < 25000 && ops < 1000; cyc++) begin
            @(negedge clk); since++;
            if (busy32 && done32) bad_ov++;
            if (done32) begin
                tests++; if (p32 !== exp) begin failed++;
                    $display("FAIL b2b_product sm=%b %h*%h got %h want %h", sm, a, b, p32, exp); end
                if (!first) begin
                    tests++; if (since !== 19) begin failed++; $display("FAIL b2b_interval got %0d want 19", since); end
                end
                first = 1'b0; since = 0; last_p = p32; ops++;
                a = pick32(); b = pick32(); sm = 1'($urandom);
                sm32 = sm; m32 = a; q32 = b; exp = ref32(sm, a, b);
            end else if (p32 !== last_p) bad_st++;
        end
        start32 = 1'b0;
        tests++; if (ops !== 1000) begin failed++; $display("FAIL b2b_ops_completed got %0d want 1000", ops); end
        tests++; if (bad_ov !== 0) begin failed++; $display("FAIL b2b_busy_done_overlap got %0d want 0", bad_ov); end
        tests++; if (bad_st !== 0) begin failed++; $display("FAIL b2b_product_unstable got %0d want 0", bad_st); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary32();
        test_width8();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
